// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake with a
// one-entry hold buffer, and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IF_write,
    input  logic        PC_write,
    input  logic [1:0]  addrSel,
    input  logic [25:0] JumpField,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ImemAddr,
    output logic        ImemReq,
    input  logic [31:0] ImemData,
    input  logic        ImemReady,
    output logic [31:0] PC,
    output logic [31:0] InstrID,
    output logic [31:0] PCPlus4ID,
    output logic        ValidID,
    output logic        FetchStall
);

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] hold_buf;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] fetched;
    logic        fetch_done;
    logic        redirect;

    always_comb begin
        pc_plus4    = PC + 32'd4;
        jump_target = {PCPlus4ID[31:28], JumpField, 2'b00};
        redirect    = PC_write && (addrSel == 2'd1 || addrSel == 2'd2);
        fetch_done  = (state == HELD) || ImemReady;
        fetched     = (state == HELD) ? hold_buf : ImemData;
        ImemAddr    = PC;
        ImemReq     = (state == FETCH);
        FetchStall  = (state == FETCH) && !ImemReady;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PC        <= RESET_PC;
            InstrID   <= NOP_INSTR;
            PCPlus4ID <= '0;
            ValidID   <= 1'b0;
            hold_buf  <= '0;
            state     <= FETCH;
        end else begin
            // IF/ID still captures the delay-slot fetch even when a redirect fires
            if (IF_write) begin
                if (fetch_done) begin
                    InstrID   <= fetched;
                    PCPlus4ID <= pc_plus4;
                    ValidID   <= 1'b1;
                end else begin
                    InstrID   <= NOP_INSTR;
                    ValidID   <= 1'b0;
                end
            end

            if (redirect) begin
                PC <= (addrSel == 2'd1) ? jump_target : BranchTarget;
            end else if (PC_write && fetch_done) begin
                PC <= pc_plus4;
            end

            // Redirect drops any buffered word and wins over a new capture
            if (redirect) begin
                state <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        if (ImemReady && !IF_write) begin
                            hold_buf <= ImemData;
                            state    <= HELD;
                        end
                    end
                    HELD: begin
                        if (IF_write) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expectations are queued per step and checked
// against the DUT outputs one cycle later through immediate assertions.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IF_write;
    logic        PC_write;
    logic [1:0]  addrSel;
    logic [25:0] JumpField;
    logic [31:0] BranchTarget;
    logic [31:0] ImemAddr;
    logic        ImemReq;
    logic [31:0] ImemData;
    logic        ImemReady;
    logic [31:0] PC;
    logic [31:0] InstrID;
    logic [31:0] PCPlus4ID;
    logic        ValidID;
    logic        FetchStall;
    logic        corrupt;

    int errors = 0;
    int checks = 0;

    localparam int S_PC     = 0;
    localparam int S_INSTR  = 1;
    localparam int S_P4     = 2;
    localparam int S_VALID  = 3;
    localparam int S_STALL  = 4;
    localparam int S_REQ    = 5;
    localparam int S_ADDR   = 6;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .IF_write    (IF_write),
        .PC_write    (PC_write),
        .addrSel     (addrSel),
        .JumpField   (JumpField),
        .BranchTarget(BranchTarget),
        .ImemAddr    (ImemAddr),
        .ImemReq     (ImemReq),
        .ImemData    (ImemData),
        .ImemReady   (ImemReady),
        .PC          (PC),
        .InstrID     (InstrID),
        .PCPlus4ID   (PCPlus4ID),
        .ValidID     (ValidID),
        .FetchStall  (FetchStall)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Corrupting the bus proves a word really came from the hold buffer
    always_comb ImemData = mem(ImemAddr) ^ (corrupt ? 32'hDEAD_BEEF : 32'h0);

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_PC:    return PC;
            S_INSTR: return InstrID;
            S_P4:    return PCPlus4ID;
            S_VALID: return {31'b0, ValidID};
            S_STALL: return {31'b0, FetchStall};
            S_REQ:   return {31'b0, ImemReq};
            default: return ImemAddr;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        drain();
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] p4,
                               input logic valid);
        expect_val({tag, "_pc"}, S_PC, pc);
        expect_val({tag, "_instr"}, S_INSTR, instr);
        expect_val({tag, "_p4"}, S_P4, p4);
        expect_val({tag, "_valid"}, S_VALID, {31'b0, valid});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        IF_write = 1'b1;
        PC_write = 1'b1;
        addrSel = 2'd0;
        JumpField = '0;
        BranchTarget = '0;
        ImemReady = 1'b1;
        corrupt = 1'b0;
        #2;
        expect_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        expect_val("reset_req", S_REQ, 32'd1);
        drain();
        Rst = 1'b0;

        // zero-wait streaming
        expect_ifid("seq0", 32'h4, mem(32'h0), 32'h4, 1'b1);
        tick();
        expect_ifid("seq1", 32'h8, mem(32'h4), 32'h8, 1'b1);
        tick();

        // memory wait states at PC=8
        ImemReady = 1'b0;
        #1;
        expect_val("wait_stall", S_STALL, 32'd1);
        expect_val("wait_req", S_REQ, 32'd1);
        drain();
        expect_ifid("wait1", 32'h8, 32'h0, 32'h8, 1'b0);
        tick();
        expect_ifid("wait2", 32'h8, 32'h0, 32'h8, 1'b0);
        tick();
        ImemReady = 1'b1;
        #1;
        expect_val("resume_stall", S_STALL, 32'd0);
        drain();
        expect_ifid("resume", 32'hC, mem(32'h8), 32'hC, 1'b1);
        tick();

        // load-use hazard at PC=C captures into the hold buffer
        IF_write = 1'b0;
        PC_write = 1'b0;
        expect_ifid("hold", 32'hC, mem(32'h8), 32'hC, 1'b1);
        expect_val("hold_req", S_REQ, 32'd0);
        expect_val("hold_stall", S_STALL, 32'd0);
        tick();
        IF_write = 1'b1;
        PC_write = 1'b1;
        ImemReady = 1'b0;
        corrupt = 1'b1;
        expect_ifid("unhold", 32'h10, mem(32'hC), 32'h10, 1'b1);
        tick();
        corrupt = 1'b0;
        ImemReady = 1'b1;

        // branch with delay slot into the 0x1000_xxxx region
        addrSel = 2'd2;
        BranchTarget = 32'h1000_0008;
        expect_ifid("br_slot", 32'h1000_0008, mem(32'h10), 32'h14, 1'b1);
        tick();
        addrSel = 2'd0;
        expect_ifid("seq_hi", 32'h1000_000C, mem(32'h1000_0008), 32'h1000_000C, 1'b1);
        tick();
        // PC advances while IF/ID stalls, leaving a buffered word behind
        IF_write = 1'b0;
        expect_ifid("adv_hold", 32'h1000_0010, mem(32'h1000_0008), 32'h1000_000C, 1'b1);
        expect_val("adv_hold_req", S_REQ, 32'd0);
        tick();

        // jump drops the buffered word
        addrSel = 2'd1;
        JumpField = 26'h000_0040;
        expect_ifid("jump", 32'h1000_0100, mem(32'h1000_0008), 32'h1000_000C, 1'b1);
        expect_val("jump_req", S_REQ, 32'd1);
        expect_val("jump_addr", S_ADDR, 32'h1000_0100);
        tick();
        IF_write = 1'b1;
        addrSel = 2'd0;
        expect_ifid("post_jump", 32'h1000_0104, mem(32'h1000_0100), 32'h1000_0104, 1'b1);
        tick();

        // branch while the fetch is still pending
        addrSel = 2'd2;
        BranchTarget = 32'h0000_0200;
        ImemReady = 1'b0;
        expect_ifid("br_pend", 32'h200, 32'h0, 32'h1000_0104, 1'b0);
        tick();

        // reserved select behaves as sequential; PC wraps at the top
        ImemReady = 1'b1;
        BranchTarget = 32'hFFFF_FFFC;
        expect_ifid("br_top", 32'hFFFF_FFFC, mem(32'h200), 32'h204, 1'b1);
        tick();
        addrSel = 2'd3;
        expect_ifid("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
        tick();

        // async reset in the middle of a cycle while in HELD
        addrSel = 2'd0;
        expect_ifid("pre_rst", 32'h4, mem(32'h0), 32'h4, 1'b1);
        tick();
        IF_write = 1'b0;
        PC_write = 1'b0;
        expect_val("pre_rst_req", S_REQ, 32'd0);
        tick();
        #2;
        Rst = 1'b1;
        #1;
        expect_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        expect_val("async_rst_req", S_REQ, 32'd1);
        drain();
        #3;
        Rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
